// File: rtl/midi_pkg.sv
// Shared types, constants and the status-byte length decoder for the MIDI input parser.
package midi_pkg;

  localparam logic [7:0] ST_SYSEX = 8'hF0;
  localparam logic [7:0] ST_EOX   = 8'hF7;
  localparam logic [7:0] ST_TUNE  = 8'hF6;
  localparam logic [7:0] RT_BASE  = 8'hF8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_D1,
    WAIT_D2,
    SYSEX
  } parser_state_e;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [1:0] len;
  } midi_msg_t;

  // Number of data bytes that follow a status byte; 0 for anything that carries none.
  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    case (status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
      4'hC, 4'hD:                   len = 2'd1;
      4'hF: begin
        case (status[3:0])
          4'h1, 4'h3: len = 2'd1;
          4'h2:       len = 2'd2;
          default:    len = 2'd0;
        endcase
      end
      default: len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_in_parser_if.sv
// Byte input, message output handshake and status signals of the MIDI input parser.
interface midi_in_parser_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       rx_byte_i;
  logic             rx_valid_i;
  logic [23:0]      msg_o;
  logic [1:0]       msg_len_o;
  logic             msg_valid_o;
  logic             msg_ready_i;
  logic [LVL_W-1:0] level_o;
  logic             overflow_o;
  logic             clear_i;

  modport master (
    output rx_byte_i, rx_valid_i, msg_ready_i, clear_i,
    input  msg_o, msg_len_o, msg_valid_o, level_o, overflow_o
  );

  modport slave (
    input  rx_byte_i, rx_valid_i, msg_ready_i, clear_i,
    output msg_o, msg_len_o, msg_valid_o, level_o, overflow_o
  );
endinterface

// File: rtl/midi_msg_fifo.sv
// First-word-fall-through queue of parsed MIDI messages; a full queue still accepts a push
// when a pop happens in the same cycle.
module midi_msg_fifo
  import midi_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  midi_msg_t        wdata,
  input  logic             pop,
  input  logic             flush,
  output midi_msg_t        head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  midi_msg_t        mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_LEVEL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = count;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Flush wins over push and pop; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/midi_in_parser.sv
// Assembles UART bytes into MIDI messages (running status, SysEx skip, real-time interleave).
// Define MIDI_RT_PASS_EN to also queue real-time bytes as single-byte messages.
module midi_in_parser
  import midi_pkg::*;
#(
  parameter  int FIFO_DEPTH = 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  midi_in_parser_if.slave bus
);

  parser_state_e    state;
  logic [7:0]       status_q;
  logic [7:0]       data1_q;
  logic             rs_valid_q;
  midi_msg_t        out_q;
  logic             out_valid_q;
  logic             overflow_q;

  logic [7:0]       rx_byte;
  logic             is_rt;
  logic             out_hold;
  logic             fifo_push;
  midi_msg_t        fifo_wdata;
  midi_msg_t        head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [LVL_W-1:0] fifo_level;

  assign rx_byte  = bus.rx_byte_i;
  assign is_rt    = (rx_byte >= RT_BASE);
  assign fifo_pop = !fifo_empty && bus.msg_ready_i;

`ifdef MIDI_RT_PASS_EN
  // Real-time bytes take the write slot immediately; a completed message waiting in out_q
  // simply stays there one more cycle.
  logic rt_push;
  assign rt_push    = bus.rx_valid_i && is_rt && (rx_byte != 8'hF9) && (rx_byte != 8'hFD);
  assign out_hold   = rt_push;
  assign fifo_push  = rt_push || out_valid_q;
  assign fifo_wdata = rt_push ? '{status: rx_byte, data1: 8'h00, data2: 8'h00, len: 2'd1}
                              : out_q;
`else
  assign out_hold   = 1'b0;
  assign fifo_push  = out_valid_q;
  assign fifo_wdata = out_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      status_q    <= '0;
      data1_q     <= '0;
      rs_valid_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (bus.clear_i) begin
      state       <= IDLE;
      status_q    <= '0;
      data1_q     <= '0;
      rs_valid_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_q && out_hold;
      if (fifo_push && fifo_full && !fifo_pop) overflow_q <= 1'b1;

      if (bus.rx_valid_i && !is_rt) begin
        if (rx_byte[7]) begin
          // Any status byte aborts a partial message or SysEx and is then handled fresh.
          if (rx_byte < ST_SYSEX) begin
            status_q   <= rx_byte;
            rs_valid_q <= 1'b1;
            state      <= WAIT_D1;
          end else if (rx_byte == ST_SYSEX) begin
            rs_valid_q <= 1'b0;
            state      <= SYSEX;
          end else if (midi_data_len(rx_byte) != 2'd0) begin
            status_q   <= rx_byte;
            rs_valid_q <= 1'b0;
            state      <= WAIT_D1;
          end else begin
            rs_valid_q <= 1'b0;
            state      <= IDLE;
            if (rx_byte == ST_TUNE) begin
              out_q       <= '{status: rx_byte, data1: 8'h00, data2: 8'h00, len: 2'd1};
              out_valid_q <= 1'b1;
            end
          end
        end else if (state == WAIT_D1 || (state == IDLE && rs_valid_q)) begin
          if (midi_data_len(status_q) == 2'd1) begin
            out_q       <= '{status: status_q, data1: rx_byte, data2: 8'h00, len: 2'd2};
            out_valid_q <= 1'b1;
            state       <= IDLE;
          end else begin
            data1_q <= rx_byte;
            state   <= WAIT_D2;
          end
        end else if (state == WAIT_D2) begin
          out_q       <= '{status: status_q, data1: data1_q, data2: rx_byte, len: 2'd3};
          out_valid_q <= 1'b1;
          state       <= IDLE;
        end
      end
    end
  end

  midi_msg_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .flush (bus.clear_i),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bus.msg_o       = {head.status, head.data1, head.data2};
  assign bus.msg_len_o   = head.len;
  assign bus.msg_valid_o = !fifo_empty;
  assign bus.level_o     = fifo_level;
  assign bus.overflow_o  = overflow_q;

endmodule
